// File: rtl/bit_serial_adder.sv
// Bit-serial unsigned adder: one add cell plus a registered carry resolves one bit
// per clock, LSB first, giving {cout,sum} = a + b after WIDTH bit steps.
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_sum_bit;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Single full-add cell on the current LSBs and the stored carry.
    assign w_sum_bit   = r_a_sr[0] ^ r_b_sr[0] ^ r_carry;
    assign w_carry_nxt = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_carry) | (r_b_sr[0] & r_carry);
    assign w_res_nxt   = {w_sum_bit, r_res_sr[WIDTH-1:1]};

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);

    // NOTE: every register here uses <= so all updates see pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_carry  <= w_carry_nxt;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_res_sr <= w_res_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    // Last bit: publish the result on the same edge it is formed.
                    if (r_cnt == LAST_BIT) begin
                        sum     <= w_res_nxt;
                        cout    <= w_carry_nxt;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH=8.
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One complete operation; a/b are scrambled after the start edge.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                          input logic [WIDTH:0] exp, input string tag);
        int edges;
        int busy_cycles;
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~ta;
        b     = ~tb_v;
        edges = 0;
        busy_cycles = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        // done appears after edge WIDTH counted from the start edge.
        check({tag, "_latency"}, 32'(edges), 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(WIDTH));
        check({tag, "_result"}, 32'({cout, sum}), 32'(exp));
        tick();
        check({tag, "_done_pulse"}, 32'({busy, done}), 32'd0);
        check({tag, "_result_held"}, 32'({cout, sum}), 32'(exp));
    endtask

    initial begin
        int dc;
        logic [WIDTH:0] exp_res;
        int last_done;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_idle", 32'({busy, done, cout, sum}), 32'd0);
        end

        // 2, 3: directed sums
        run_op(8'hA5, 8'h5A, 9'h0FF, "a5_5a");
        run_op(8'hFF, 8'h01, 9'h100, "ff_01");
        run_op(8'hFF, 8'hFF, 9'h1FE, "ff_ff");
        run_op(8'h00, 8'h00, 9'h000, "00_00");

        // 4: start during RUN is ignored
        a = 8'h10;
        b = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        dc = 0;
        exp_res = '1;
        for (int i = 1; i <= 14; i++) begin
            if (i == 3) begin
                start = 1'b1;
                a = 8'h01;
                b = 8'h01;
            end
            if (i == 4) start = 1'b0;
            tick();
            if (done) begin
                dc++;
                exp_res = {cout, sum};
            end
        end
        check("ignore_start_pulses", 32'(dc), 32'd1);
        check("ignore_start_result", 32'(exp_res), 32'h030);
        check("ignore_start_idle", 32'(busy), 32'd0);

        // 5: reset mid-operation
        a = 8'h77;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        check("async_rst_clear", 32'({busy, done, cout, sum}), 32'd0);
        tick();
        rst = 1'b0;
        dc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) dc++;
        end
        check("rst_abort_no_activity", 32'(dc), 32'd0);
        check("rst_abort_sum", 32'({cout, sum}), 32'd0);
        run_op(8'h12, 8'h34, 9'h046, "post_rst");

        // 6: back-to-back with start held high
        last_done = 0;
        start = 1'b1;
        for (int op = 0; op < 20; op++) begin
            int edges;
            a = WIDTH'($urandom_range(0, 255));
            b = WIDTH'($urandom_range(0, 255));
            exp_res = {1'b0, a} + {1'b0, b};
            tick();
            a = WIDTH'($urandom_range(0, 255));
            b = WIDTH'($urandom_range(0, 255));
            edges = 0;
            while (!done && edges < 20) begin
                tick();
                edges++;
            end
            check("stream_done_seen", 32'(done), 32'd1);
            check("stream_result", 32'({cout, sum}), 32'(exp_res));
            if (op > 0) check("stream_period", 32'(cyc - last_done), 32'(WIDTH + 2));
            last_done = cyc;
            tick();
        end
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
